bcd_down_timer: RTL

- Parametrised multi-digit BCD countdown timer. Generalises the single mod-6 down-counter digit into a DIGITS-wide chain with a per-digit modulus, borrow ripple, start/stop/pause control and a terminal-count pulse.
- Sits in the timer datapath of the microwave controller. Driven by a 1-per-second `enabled` strobe; feeds the display and the cook-done logic.

---
 rtl/bcd_down_timer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with per-digit reload modulus, start/stop/pause control and done pulse.
// Optional periodic mode: define TIMER_AUTO_RELOAD_EN to reload from the last loaded value on terminal count.
module bcd_down_timer #(
    parameter int                      DIGITS    = 4,
    parameter logic [4*DIGITS-1:0]     DIGIT_MAX = 16'h9959
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enabled,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  zero,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    count_nxt;
    logic            done_nxt;
    logic [W-1:0]    load_sat;
    logic [W-1:0]    count_dec;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [W-1:0]    reload, reload_nxt;
`endif

    // Clamp each incoming nibble to a legal BCD digit.
    always_comb begin
        load_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Borrow ripples upward: a zero digit reloads to its modulus and passes the borrow on.
    always_comb begin
        logic borrow;
        borrow    = 1'b1;
        count_dec = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = DIGIT_MAX[4*i +: 4];
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        done_nxt   = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        reload_nxt = reload;
`endif
        if (load) begin
            count_nxt = load_sat;
            state_nxt = S_IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
            reload_nxt = load_sat;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !zero) state_nxt = S_RUN;
                end
                S_PAUSE: begin
                    if (stop) begin
                        state_nxt = S_IDLE;
                        count_nxt = '0;
                    end else if (start && !zero) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_nxt = S_PAUSE;
                    end else if (enabled && !zero) begin
                        count_nxt = count_dec;
                        if (count_dec == '0) begin
                            done_nxt  = 1'b1;
                            state_nxt = S_DONE;
`ifdef TIMER_AUTO_RELOAD_EN
                            if (reload != '0) begin
                                count_nxt = reload;
                                state_nxt = S_RUN;
                            end
`endif
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            done   <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            done   <= done_nxt;
`ifdef TIMER_AUTO_RELOAD_EN
            reload <= reload_nxt;
`endif
        end
    end

    assign running = (state == S_RUN);
    assign zero    = (count == '0);

endmodule
